// File: rtl/matrix_alu_pkg.sv
// rtl/matrix_alu_pkg.sv - opcodes, FSM states and index helper for the matrix ALU
package matrix_alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_WR_A  = 3'd0,
    OP_WR_B  = 3'd1,
    OP_RD_R  = 3'd2,
    OP_TRANS = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6,
    OP_SCALE = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic int unsigned flat_idx(input int unsigned row, input int unsigned col,
                                           input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matrix_alu_if.sv
// rtl/matrix_alu_if.sv - command/response bus of the matrix ALU
interface matrix_alu_if
  import matrix_alu_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 32,
  parameter int IW = $clog2(N*N)
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [IW-1:0]   cmd_idx;
  logic [W-1:0]    cmd_data;
  logic            rsp_valid;
  logic [W-1:0]    rsp_data;
  logic            rsp_err;
  logic            busy;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/mat_idx_counter.sv
// rtl/mat_idx_counter.sv - row/col(/k) sweep counter shared by elementwise and MUL ops
module mat_idx_counter #(
  parameter int N  = 3,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  input  logic          mode_3d,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] k,
  output logic          last
);
  localparam logic [CW-1:0] MAX = CW'(N - 1);

  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  // k is innermost; in 2D mode it stays at 0 and j advances every step
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (start) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (step) begin
      if (mode_3d && k_q != MAX) begin
        k_d = k_q + CW'(1);
      end else begin
        k_d = '0;
        if (j_q != MAX) begin
          j_d = j_q + CW'(1);
        end else begin
          j_d = '0;
          i_d = (i_q != MAX) ? i_q + CW'(1) : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign k    = k_q;
  assign last = (i_q == MAX) && (j_q == MAX) && (!mode_3d || k_q == MAX);
endmodule

// File: rtl/matrix_alu_seq.sv
// rtl/matrix_alu_seq.sv - sequential NxN matrix ALU compute slave
module matrix_alu_seq
  import matrix_alu_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 32,
  parameter int IW = $clog2(N*N)
) (
  input logic         clk,
  input logic         reset,
  matrix_alu_if.slave bus
);
  localparam int NN = N * N;
  localparam int CW = $clog2(N);
  localparam logic [IW:0] NN_L = (IW+1)'(NN);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] scalar_q, scalar_d, acc_q, acc_d;
  logic [W-1:0] a_q [NN];
  logic [W-1:0] a_d [NN];
  logic [W-1:0] b_q [NN];
  logic [W-1:0] b_d [NN];
  logic [W-1:0] r_q [NN];
  logic [W-1:0] r_d [NN];
  logic         rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;

  logic          accept, idx_ok, cnt_start, cnt_last;
  op_e           cmd_op;
  logic [CW-1:0] ci, cj, ck;
  logic [IW-1:0] e_ij, e_ji, e_ik, e_kj;
  logic [W-1:0]  prod, mac;

  assign cmd_op        = op_e'(bus.cmd_op);
  assign bus.cmd_ready = (state_q == S_IDLE) && reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign idx_ok        = {1'b0, bus.cmd_idx} < NN_L;
  assign cnt_start     = accept && (cmd_op >= OP_TRANS);

  mat_idx_counter #(.N(N), .CW(CW)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (cnt_start),
    .step    (state_q == S_RUN),
    .mode_3d (op_q == OP_MUL),
    .i       (ci),
    .j       (cj),
    .k       (ck),
    .last    (cnt_last)
  );

  assign e_ij = IW'(flat_idx(32'(ci), 32'(cj), N));
  assign e_ji = IW'(flat_idx(32'(cj), 32'(ci), N));
  assign e_ik = IW'(flat_idx(32'(ci), 32'(ck), N));
  assign e_kj = IW'(flat_idx(32'(ck), 32'(cj), N));
  assign prod = a_q[e_ik] * b_q[e_kj];
  assign mac  = ((ck == '0) ? '0 : acc_q) + prod;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    scalar_d    = scalar_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WR_A, OP_WR_B: begin
              if (!idx_ok) begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
              end else if (cmd_op == OP_WR_A) begin
                a_d[bus.cmd_idx] = bus.cmd_data;
              end else begin
                b_d[bus.cmd_idx] = bus.cmd_data;
              end
            end
            OP_RD_R: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              if (idx_ok) rsp_data_d = r_q[bus.cmd_idx];
              else        rsp_err_d  = 1'b1;
            end
            default: begin
              state_d  = S_RUN;
              op_d     = cmd_op;
              scalar_d = bus.cmd_data;
            end
          endcase
        end
      end
      S_RUN: begin
        case (op_q)
          OP_TRANS: r_d[e_ij] = a_q[e_ji];
          OP_ADD:   r_d[e_ij] = a_q[e_ij] + b_q[e_ij];
          OP_SUB:   r_d[e_ij] = a_q[e_ij] - b_q[e_ij];
          OP_SCALE: r_d[e_ij] = scalar_q * a_q[e_ij];
          OP_MUL: begin
            acc_d = mac;
            if (ck == CW'(N - 1)) r_d[e_ij] = mac;
          end
          default: ;
        endcase
        if (cnt_last) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR_A;
      scalar_q    <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        r_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      scalar_q    <= scalar_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q == S_RUN);
endmodule

// File: tb/tb_matrix_alu_seq.sv
// tb/tb_matrix_alu_seq.sv - scoreboard bench for matrix_alu_seq against a matrix-level model
module tb_matrix_alu_seq;
  import matrix_alu_pkg::*;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_alu_if #(.N(N), .W(W)) bus ();
  matrix_alu_seq #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  rsp_t         exp_q[$];
  rsp_t         cur;
  logic [W-1:0] ma[NN];
  logic [W-1:0] mb[NN];
  logic [W-1:0] mr[NN];
  int           n_vec  = 0;
  int           n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < NN; n++) begin
      ma[n] = '0;
      mb[n] = '0;
      mr[n] = '0;
    end
  endtask

  // Whole-matrix reference; every op rewrites all of R
  task automatic model_op(input op_e op, input logic [W-1:0] s);
    logic [W-1:0] t[NN];
    logic [W-1:0] acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        case (op)
          OP_TRANS: t[i*N+j] = ma[j*N+i];
          OP_ADD:   t[i*N+j] = ma[i*N+j] + mb[i*N+j];
          OP_SUB:   t[i*N+j] = ma[i*N+j] - mb[i*N+j];
          OP_SCALE: t[i*N+j] = s * ma[i*N+j];
          default: begin
            acc = '0;
            for (int k = 0; k < N; k++) acc = acc + ma[i*N+k] * mb[k*N+j];
            t[i*N+j] = acc;
          end
        endcase
      end
    mr = t;
  endtask

  always @(negedge clk) begin
    if (reset && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", bus.rsp_data,
                 bus.rsp_err);
      end else begin
        cur = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, cur.data);
        check("rsp_err", bus.rsp_err, cur.err);
      end
    end
  end

  task automatic issue(input op_e op, input int idx, input logic [W-1:0] data);
    int w, lat, bc, exp_lat, exp_busy;
    rsp_t e;
    exp_lat  = 0;
    exp_busy = 0;
    e.data   = '0;
    e.err    = 1'b0;
    case (op)
      OP_WR_A, OP_WR_B: begin
        if (idx < NN) begin
          if (op == OP_WR_A) ma[idx] = data;
          else mb[idx] = data;
        end else begin
          e.err = 1'b1;
          exp_q.push_back(e);
          exp_lat = 1;
        end
      end
      OP_RD_R: begin
        if (idx < NN) e.data = mr[idx];
        else e.err = 1'b1;
        exp_q.push_back(e);
        exp_lat = 1;
      end
      default: begin
        model_op(op, data);
        exp_q.push_back(e);
        exp_busy = (op == OP_MUL) ? N*N*N : N*N;
        exp_lat  = exp_busy + 1;
      end
    endcase
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = IW'(idx);
    bus.cmd_data  = data;
    w = 0;
    while (!bus.cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("accept_timeout", 64'(w), 64'(0));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (exp_lat > 0) begin
      lat = 0;
      bc  = 0;
      do begin
        @(negedge clk);
        lat++;
        if (bus.busy) bc++;
      end while (!bus.rsp_valid && lat < 2000);
      check("latency", 64'(lat), 64'(exp_lat));
      check("busy_cycles", 64'(bc), 64'(exp_busy));
      @(negedge clk);
      check("ready_after_rsp", bus.cmd_ready, 1);
    end
  endtask

  task automatic read_all();
    for (int n = 0; n < NN; n++) issue(OP_RD_R, n, '0);
  endtask

  int bc;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_idx   = '0;
    bus.cmd_data  = '0;
    reset         = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.cmd_ready, 1);
    read_all();

    for (int n = 0; n < NN; n++) begin
      issue(OP_WR_A, n, W'(n));
      issue(OP_WR_B, n, W'(n));
    end
    issue(OP_TRANS, 0, '0);
    read_all();
    for (int n = 0; n < NN; n++) issue(OP_WR_B, n, W'(8 - n));
    issue(OP_ADD, 5, '0);
    read_all();
    issue(OP_SUB, 0, '0);
    read_all();
    for (int n = 0; n < NN; n++) issue(OP_WR_B, n, W'(n));
    issue(OP_MUL, 0, '0);
    read_all();

    issue(OP_WR_A, 0, 100);
    issue(OP_WR_A, 1, -3);
    issue(OP_SCALE, 0, 2);
    read_all();

    issue(OP_WR_A, 9, 7);
    issue(OP_RD_R, 15, '0);
    issue(OP_TRANS, 0, '0);
    read_all();

    repeat (6) begin
      for (int n = 0; n < NN; n++) begin
        issue(OP_WR_A, n, $urandom());
        issue(OP_WR_B, n, ($urandom_range(0, 1) == 1) ? $urandom() : W'($urandom_range(0, 20)));
      end
      if ($urandom_range(0, 1) == 1) issue(OP_WR_B, $urandom_range(NN, 15), $urandom());
      issue(op_e'($urandom_range(3, 7)), $urandom_range(0, 15), $urandom());
      read_all();
    end

    // Abort a MUL with reset partway through
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_MUL;
    bus.cmd_idx   = '0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bc = 0;
    for (int c = 0; c < 100 && bc < 10; c++) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    check("abort_busy_seen", 64'(bc), 64'(10));
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_ready", bus.cmd_ready, 0);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check("ready_after_abort", bus.cmd_ready, 1);
    read_all();

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/matrix_alu_seq.md
# matrix_alu_seq

Parametrised sequential N×N matrix ALU that succeeds the fixed 3×3 select-driven matrix ALU. It holds operand matrices A and B and a result matrix R, loads and reads elements through a valid/ready command port, and computes transpose, add, subtract, multiply and scalar-scale as multi-cycle operations. It sits behind the system command bus as a compute slave.

## Interface
- `N`, default 3: matrix dimension, range 2..8.
- `W`, default 32: element width, two's complement.
- `IW`, default `$clog2(N*N)`: element index width (derived).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block accepts a command; transfer occurs when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  3  opcode.
- `cmd_idx`  in  IW  row-major element index, `row*N+col`.
- `cmd_data`  in  W  write data, or scalar for SCALE.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  W  read data; 0 for non-read responses.
- `rsp_err`  out  1  qualifies `rsp_valid`; bad index.
- `busy`  out  1  an arithmetic operation is in progress.

## Operation
- Opcodes:
  - 0 WR_A: `A[idx]=data`.
  - 1 WR_B: `B[idx]=data`.
  - 2 RD_R: returns `R[idx]`.
  - 3 TRANS: `R=Aᵀ`.
  - 4 ADD: `R=A+B`.
  - 5 SUB: `R=A−B`.
  - 6 MUL: `R=A·B`.
  - 7 SCALE: `R=data·A`. The scalar is captured at acceptance.
- States:
  - IDLE → RUN on acceptance of ops 3–7.
  - IDLE → RESP on acceptance of RD_R.
  - IDLE → RESP on WR_A/WR_B with a bad index.
  - RUN → RESP when the last element is written.
  - RESP → IDLE always.
  - A WR_A/WR_B with a valid index stays in IDLE and produces no response.
- `cmd_ready` = (state==IDLE) && reset. It is therefore 0 during RUN, RESP and reset.
- `busy` = (state==RUN).
- Elementwise ops (3, 4, 5, 7):
  - One element per cycle, with i (row) outer and j (col) inner, for N² cycles.
  - TRANS writes `R[i][j]=A[j][i]`.
- MUL:
  - Nested i, j, k counters with a W-bit accumulator; one MAC per cycle, for N³ cycles.
  - The accumulator is cleared at k=0.
  - `R[i][j]` is written on the k=N−1 cycle.
- Arithmetic: all sums, differences and products are truncated to the low W bits (wrap, no saturation, no flags).
- Operands stay stable during RUN because no writes can be accepted. A and B are never modified by ops.
- R is overwritten element by element. Unwritten elements keep their prior values until written.
- Index checking:
  - `idx >= N*N` on WR_A/WR_B/RD_R: no storage change, response `rsp_err=1`, `rsp_data=0`.
  - `cmd_idx` is ignored for ops 3–7.
- RESP after RUN: `rsp_valid=1`, `rsp_data=0`, `rsp_err=0`.

## Timing
- Reset values: state IDLE; A, B, R all 0; counters 0; `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `cmd_ready` all 0.
- WR_A/WR_B: the element is updated at the acceptance edge and is readable by the next command.
- RD_R:
  - `rsp_valid` is high in the cycle after acceptance.
  - `cmd_ready` returns high one cycle later.
  - The minimum read throughput is one per 2 cycles.
- Ops 3, 4, 5, 7:
  - `busy` is high for exactly N² cycles starting the cycle after acceptance.
  - `rsp_valid` follows in the next cycle, so latency is N²+1 cycles.
- MUL: `busy` is high for N³ cycles, and `rsp_valid` is at N³+1 cycles.
- `cmd_valid` held while `cmd_ready`=0 is not accepted. Commands are not queued.
- Reset low mid-RUN or mid-RESP:
  - The op is aborted and all state returns to reset values at that edge.
  - No response is issued.
  - R is cleared.

## Structure
- `matrix_alu_pkg` holds:
  - the opcode localparams/enum (`OP_WR_A` … `OP_SCALE`);
  - the state enum (`S_IDLE`, `S_RUN`, `S_RESP`);
  - an index helper function `(row,col) → row*N+col`.
- Sub-module `mat_idx_counter`:
  - parametrised by N and a 2D/3D mode bit;
  - provides i/j/k counters with `start`, `step` and `last` outputs;
  - shared by the elementwise and MUL paths.
- Storage is a flat register array of N² × W per matrix.

## Test plan
- N=3, W=32. Load A=0..8 and B=0..8 (idx=value), run TRANS, then read all 9. Expect R=0 3 6 / 1 4 7 / 2 5 8, `busy` high 9 cycles, `rsp_valid` at cycle 10.
- Same A, with B=8..0. Run ADD: R=all 8. Run SUB: R=−8 −6 −4 −2 0 2 4 6 8.
- A=B=0..8. Run MUL: R=15 18 21 / 42 54 66 / 69 90 111, `busy` exactly 27 cycles.
- W=8. A[0]=100, SCALE with data=2: R[0]=8'hC8. A[1]=−3 with data=2: R[1]=8'hFA.
- WR_A idx=9 with data=7 (N=3): `rsp_err`=1, `rsp_data`=0, A unchanged. RD_R idx=15: `rsp_err`=1.
- Start MUL, assert reset low at busy cycle 10. Expect no `rsp_valid`. Then RD_R idx=0 returns 0, and `cmd_ready` is 1 the cycle after reset releases.
